// File: rtl/nibble_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// nibble_ctrl_pkg
// Shared definitions for the nibble-serial adder controller.
//   state_t   : controller FSM states (IDLE / RUN / DONE)
//   NIBBLE_W  : width of the time-shared adder slice
//   idxWidth  : width of the nibble index counter for a given nibble count
// ---------------------------------------------------------------------------
package nibble_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  // Index counter width; a single-nibble count still needs one bit so the
  // counter never collapses to a zero-width vector.
  function automatic int idxWidth(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// ---------------------------------------------------------------------------
// carry_lookahead_adder
// 4-bit carry-lookahead adder slice.
//   A, B  : 4-bit addends
//   Cin   : carry into bit 0
//   S     : 4-bit sum
//   Cout  : carry INTO bit 3 (not out of bit 3); callers that need the real
//           carry-out must combine it with the bit-3 operand bits themselves
// ---------------------------------------------------------------------------
module carry_lookahead_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  logic [3:0] w_gen;
  logic [3:0] w_prop;
  logic [3:0] w_carry;

  // Generate/propagate terms and the flattened lookahead carry equations
  // for carries into bits 0..3.
  always_comb begin
    w_gen      = A & B;
    w_prop     = A ^ B;
    w_carry[0] = Cin;
    w_carry[1] = w_gen[0] | (w_prop[0] & Cin);
    w_carry[2] = w_gen[1] | (w_prop[1] & w_gen[0]) | (w_prop[1] & w_prop[0] & Cin);
    w_carry[3] = w_gen[2] | (w_prop[2] & w_gen[1]) | (w_prop[2] & w_prop[1] & w_gen[0])
               | (w_prop[2] & w_prop[1] & w_prop[0] & Cin);
    S          = w_prop ^ w_carry;
    Cout       = w_carry[3];
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl
// WIDTH-bit add/subtract built from one 4-bit carry-lookahead slice that is
// stepped across the operands one nibble per cycle, LSB nibble first.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, cin, sub)
//   sub                 : 0 = a + b + cin, 1 = a - b (cin ignored)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   cout                : carry out of the MSB (1 = no borrow on subtract)
//   ovf                 : two's-complement signed overflow
// ---------------------------------------------------------------------------
module nibble_serial_adder_ctrl
  import nibble_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int                 NIBBLES  = WIDTH / NIBBLE_W;
  localparam int                 IDX_W    = idxWidth(NIBBLES);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t                r_state;
  state_t                w_nextState;
  logic [WIDTH-1:0]      r_opA;
  logic [WIDTH-1:0]      r_opB;
  logic [WIDTH-1:0]      r_sum;
  logic                  r_carry;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_cout;
  logic                  r_ovf;

  logic [NIBBLE_W-1:0]   w_nibA;
  logic [NIBBLE_W-1:0]   w_nibB;
  logic [NIBBLE_W-1:0]   w_nibSum;
  logic                  w_claCout;
  logic                  w_trueCarry;
  logic                  w_accept;
  logic                  w_resultTaken;
  logic                  w_lastNib;

  // The slice currently being processed; subtraction was already folded
  // into r_opB (inverted) and r_carry (forced to 1) at accept time.
  assign w_nibA = r_opA[NIBBLE_W*r_idx +: NIBBLE_W];
  assign w_nibB = r_opB[NIBBLE_W*r_idx +: NIBBLE_W];

  carry_lookahead_adder u_cla (
    .A    (w_nibA),
    .B    (w_nibB),
    .Cin  (r_carry),
    .S    (w_nibSum),
    .Cout (w_claCout)
  );

  // The slice reports the carry into bit 3, so the real carry out of the
  // nibble is rebuilt from the bit-3 operand bits: generate, or propagate
  // that incoming carry.
  assign w_trueCarry   = (w_nibA[3] & w_nibB[3]) | ((w_nibA[3] ^ w_nibB[3]) & w_claCout);
  assign w_accept      = in_valid & (r_state == IDLE);
  assign w_resultTaken = out_ready & (r_state == DONE);
  assign w_lastNib     = (r_idx == LAST_IDX);

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode: accept in IDLE, walk all nibbles in RUN, then hold
  // the result in DONE until the consumer takes it.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept)      w_nextState = RUN;
      RUN:     if (w_lastNib)     w_nextState = DONE;
      DONE:    if (w_resultTaken) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, write one result nibble per RUN
  // cycle and record the final flags on the last nibble. Nothing changes in
  // DONE, which keeps the result frozen during backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opA   <= '0;
      r_opB   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_opA   <= a;
            r_opB   <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
          end
        end
        RUN: begin
          r_sum[NIBBLE_W*r_idx +: NIBBLE_W] <= w_nibSum;
          r_carry <= w_trueCarry;
          r_idx   <= r_idx + 1'b1;
          if (w_lastNib) begin
            r_cout <= w_trueCarry;
            r_ovf  <= w_claCout ^ w_trueCarry;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl
// Directed self-checking bench for the 16-bit nibble-serial adder controller.
// Each scenario task drives its own operation and compares against values
// worked out by hand.
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int passCount  = 0;
  int checkCount = 0;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Present one operation and complete the accept handshake; afterwards the
  // operand inputs are scrambled, which must not disturb the operation.
  task automatic applyStimulus(input logic [15:0] opA, input logic [15:0] opB,
                               input logic c, input logic s);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    a = opA; b = opB; cin = c; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  // Count cycles until out_valid, bounded so a stuck design still finishes.
  task automatic waitDone(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkCount++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); else passCount++;
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); else passCount++;
    checkCount++; if (sum !== 16'h0000) $display("[TB] FAIL reset_sum got %h want 0000", sum); else passCount++;
    checkCount++; if ({cout, ovf} !== 2'b00) $display("[TB] FAIL reset_flags got %b want 00", {cout, ovf}); else passCount++;
  endtask

  // Run one operation with the consumer ready on the first DONE cycle and
  // compare latency, result, flags and the return to IDLE.
  task automatic test_op(input string name, input logic [15:0] opA, input logic [15:0] opB,
                         input logic c, input logic s, input logic [15:0] expSum,
                         input logic expCout, input logic expOvf);
    int cyc;
    applyStimulus(opA, opB, c, s);
    checkCount++; if (in_ready !== 1'b0) $display("[TB] FAIL %s_in_ready_run got %b want 0", name, in_ready); else passCount++;
    waitDone(cyc);
    checkCount++; if (cyc !== 4) $display("[TB] FAIL %s_latency got %0d want 4", name, cyc); else passCount++;
    checkCount++; if (sum !== expSum) $display("[TB] FAIL %s_sum got %h want %h", name, sum, expSum); else passCount++;
    checkCount++; if (cout !== expCout) $display("[TB] FAIL %s_cout got %b want %b", name, cout, expCout); else passCount++;
    checkCount++; if (ovf !== expOvf) $display("[TB] FAIL %s_ovf got %b want %b", name, ovf, expOvf); else passCount++;
    releaseResult();
    checkCount++; if ({in_ready, out_valid} !== 2'b10) $display("[TB] FAIL %s_idle_after got %b want 10", name, {in_ready, out_valid}); else passCount++;
  endtask

  // 0x00FF + 0x0F01 = 0x1000. An in_valid pulse with other operands during
  // RUN must be ignored, and a 3-cycle stall must leave everything frozen.
  task automatic test_backpressure();
    int cyc;
    applyStimulus(16'h00FF, 16'h0F01, 1'b0, 1'b0);
    a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitDone(cyc);
    checkCount++; if (cyc !== 3) $display("[TB] FAIL bp_latency got %0d want 3", cyc); else passCount++;
    for (int i = 0; i < 3; i++) begin
      checkCount++; if (sum !== 16'h1000) $display("[TB] FAIL bp_sum_hold%0d got %h want 1000", i, sum); else passCount++;
      checkCount++; if ({cout, ovf} !== 2'b00) $display("[TB] FAIL bp_flags_hold%0d got %b want 00", i, {cout, ovf}); else passCount++;
      checkCount++; if ({in_ready, out_valid} !== 2'b01) $display("[TB] FAIL bp_hs_hold%0d got %b want 01", i, {in_ready, out_valid}); else passCount++;
      @(posedge clk); #1;
    end
    releaseResult();
    checkCount++; if ({in_ready, out_valid} !== 2'b10) $display("[TB] FAIL bp_release got %b want 10", {in_ready, out_valid}); else passCount++;
  endtask

  // Reset on the second RUN cycle, after nibble 0 (0x1+0x2) has landed.
  task automatic test_reset_mid_run();
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkCount++; if (sum !== 16'h0003) $display("[TB] FAIL midrun_partial got %h want 0003", sum); else passCount++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkCount++; if ({in_ready, out_valid} !== 2'b10) $display("[TB] FAIL midrun_hs got %b want 10", {in_ready, out_valid}); else passCount++;
    checkCount++; if (sum !== 16'h0000) $display("[TB] FAIL midrun_sum got %h want 0000", sum); else passCount++;
    test_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
  endtask

  // Consumer always ready: next accept is possible NIBBLES+2 cycles apart.
  // 0x0010-0x0001 = 0x000F (no borrow); 0x8000+0x7FFF+1 = 0x0000 carry, no ovf.
  task automatic test_back_to_back();
    int cyc;
    out_ready = 1'b1;
    applyStimulus(16'h0010, 16'h0001, 1'b0, 1'b1);
    waitDone(cyc);
    checkCount++; if (sum !== 16'h000F) $display("[TB] FAIL b2b_sum1 got %h want 000F", sum); else passCount++;
    checkCount++; if ({cout, ovf} !== 2'b10) $display("[TB] FAIL b2b_flags1 got %b want 10", {cout, ovf}); else passCount++;
    @(posedge clk); #1;
    checkCount++; if (in_ready !== 1'b1) $display("[TB] FAIL b2b_ready got %b want 1", in_ready); else passCount++;
    applyStimulus(16'h8000, 16'h7FFF, 1'b1, 1'b0);
    waitDone(cyc);
    checkCount++; if (cyc !== 4) $display("[TB] FAIL b2b_latency2 got %0d want 4", cyc); else passCount++;
    checkCount++; if (sum !== 16'h0000) $display("[TB] FAIL b2b_sum2 got %h want 0000", sum); else passCount++;
    checkCount++; if ({cout, ovf} !== 2'b10) $display("[TB] FAIL b2b_flags2 got %b want 10", {cout, ovf}); else passCount++;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkCount++; if ({in_ready, out_valid} !== 2'b10) $display("[TB] FAIL b2b_idle got %b want 10", {in_ready, out_valid}); else passCount++;
  endtask

  // Scenario sequence; each task leaves the DUT idle at posedge+1.
  initial begin
    test_reset();
    test_op("add_basic",  16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    test_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    test_op("add_ovf_p",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    test_op("add_ovf_n",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    test_op("add_cin",    16'h00FE, 16'h0000, 1'b1, 1'b0, 16'h00FF, 1'b0, 1'b0);
    test_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    test_op("sub_cin_ig", 16'h0009, 16'h0004, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0);
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencing controller that performs WIDTH-bit add/subtract by time-multiplexing a single 4-bit `carry_lookahead_adder` over successive nibbles, LSB first, with the inter-nibble carry held in a register. It sits between a requester (valid/ready operand interface) and a consumer (valid/ready result interface). The block trades latency for area in multi-nibble arithmetic paths.

## Interface
- `WIDTH`, 16, operand/result width; must be a multiple of 4, ≥ 8.
- `NIBBLES`, WIDTH/4, derived localparam, not overridable.

- `clk` in 1 single clock, rising edge.
- `rst` in 1 synchronous, active-high reset.
- `in_valid` in 1 operands presented.
- `in_ready` out 1 controller can accept.
- `a` in WIDTH operand A.
- `b` in WIDTH operand B.
- `cin` in 1 carry-in for add; ignored when `sub`=1.
- `sub` in 1 0 = A+B+cin, 1 = A−B.
- `out_valid` out 1 result available.
- `out_ready` in 1 consumer accepts result.
- `sum` out WIDTH result.
- `cout` out 1 carry out of MSB; for subtract, 1 = no borrow.
- `ovf` out 1 two's-complement signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `in_ready`=1. On `in_valid & in_ready`: register `a` into `op_a`; register `sub ? ~b : b` into `op_b`; carry_reg ← `sub ? 1 : cin`; idx ← 0; clear the sum register; → RUN.
- RUN: the CLA sees `op_a[4*idx+:4]`, `op_b[4*idx+:4]`, carry_reg. The nibble result is written to `sum[4*idx+:4]`. carry_reg ← true nibble carry-out. idx increments.
  - At idx = NIBBLES−1: `cout` ← nibble carry-out; `ovf` ← (carry into bit 3 of the nibble) XOR (nibble carry-out); → DONE.
- Nibble carry rule: the CLA `Cout` port carries the carry into nibble bit 3, not out of bit 3. The controller derives the true carry-out as `(a3&b3) | ((a3^b3) & Cout)`, using the registered operand bits.
- DONE: `out_valid`=1. `sum`, `cout` and `ovf` are held stable until `out_valid & out_ready`, then → IDLE.
- One operation in flight at a time. `in_ready`=0 in RUN and DONE.
- Input changes outside the accept edge have no effect.
- Reset (any state, including mid-RUN or DONE awaiting `out_ready`):
  - next state is IDLE and the operation is discarded;
  - `sum`=0, `cout`=0, `ovf`=0, `out_valid`=0;
  - `in_ready`=1 in the cycle after the reset edge.
- `rst` has priority over every handshake in the same cycle.

## Timing
- Accept edge E: state is RUN for edges E+1…E+NIBBLES.
- `out_valid` rises after edge E+NIBBLES. It is first visible NIBBLES cycles after accept (4 for WIDTH=16).
- If `out_ready`=1 on the first DONE cycle, the result handshake completes on that edge and `in_ready`=1 in the following cycle.
- Maximum throughput: one operation per NIBBLES+2 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from `in_valid`/`out_ready` to any output.
- The `out_ready` stall is unbounded and outputs stay frozen during it.

## Structure
- Shared package `nibble_ctrl_pkg`:
  - state enum (IDLE/RUN/DONE);
  - `NIBBLE_W`=4;
  - function computing the index width as $clog2(NIBBLES).
- One sub-module instance: `carry_lookahead_adder` (4-bit). It is unmodified; the true-carry fix-up is done in this controller.
- Datapath registers: `op_a`, `op_b`, `sum`, carry_reg, idx, `cout`, `ovf`.

## Test plan
- WIDTH=16, add 0x1234 + 0x0FFF, cin=0 -> `sum`=0x2233, `cout`=0, `ovf`=0; `out_valid` first high 4 cycles after accept.
- Add 0xFFFF + 0x0001, cin=0 -> `sum`=0x0000, `cout`=1, `ovf`=0. Exercises full carry ripple across all nibbles, including CLA `Cout` fix-up on nibble 3.
- Add 0x7FFF + 0x0001 -> `sum`=0x8000, `cout`=0, `ovf`=1. Add 0x8000 + 0x8000 -> `sum`=0x0000, `cout`=1, `ovf`=1.
- Subtract 0x0005 − 0x0007 with `cin`=0 (ignored) -> `sum`=0xFFFE, `cout`=0, `ovf`=0.
- Result backpressure and accept lockout:
  - hold `out_ready`=0 for 3 cycles in DONE -> `sum`/`cout`/`ovf` unchanged and `in_ready`=0;
  - `in_valid` pulsed during RUN -> ignored (result unchanged);
  - release `out_ready` -> IDLE next cycle.
- Assert `rst` on the second RUN cycle -> next cycle IDLE, `in_ready`=1, `out_valid`=0, `sum`=0. A new op 0x0001 + 0x0001 then gives 0x0002.
